// File: rtl/key_char_writer_pkg.sv
// Shared display package: digit geometry, blank code and the 32-bit character word
// read by the display decoders and written by the key entry front end.
package key_char_writer_pkg;

   localparam int unsigned NUM_DIGITS         = 8;
   localparam int unsigned CODE_W             = 4;
   localparam logic [3:0]  DEFAULT_BLANK_CODE = 4'hF;

   typedef logic [NUM_DIGITS*CODE_W-1:0] disp_word_t;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_PUSH,
      OP_BKSP,
      OP_COMMIT
   } edit_op_t;

   function automatic disp_word_t blank_word(input logic [CODE_W-1:0] code);
      return {NUM_DIGITS{code}};
   endfunction

endpackage

// File: rtl/key_char_writer_button_cond.sv
// Push-button conditioner: 2-flop synchronizer, debounce on the accepted level,
// and a one-cycle press event on each accepted rising edge.
module button_cond #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // The event is registered on the same edge the level toggles, so the
   // consumer sees it one edge after the debounce period completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= '0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn_raw};
         press <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
            press <= ~level;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/key_char_writer.sv
// Operator entry front end: conditions three buttons and maintains an up-to-8
// character edit buffer that is published to the display word on commit.
module key_char_writer
   import key_char_writer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter logic [3:0]  BLANK_CODE      = DEFAULT_BLANK_CODE
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [3:0]  char_in,
   input  logic        push_btn,
   input  logic        bksp_btn,
   input  logic        commit_btn,
   output logic [31:0] edit,
   output logic [31:0] Q,
   output logic [3:0]  count,
   output logic        full,
   output logic        q_valid
);

   logic     push_ev;
   logic     bksp_ev;
   logic     commit_ev;
   edit_op_t op;

   button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push (
      .clk     (CLOCK_50),
      .reset   (reset),
      .btn_raw (push_btn),
      .press   (push_ev)
   );

   button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bksp (
      .clk     (CLOCK_50),
      .reset   (reset),
      .btn_raw (bksp_btn),
      .press   (bksp_ev)
   );

   button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
      .clk     (CLOCK_50),
      .reset   (reset),
      .btn_raw (commit_btn),
      .press   (commit_ev)
   );

   // Commit wins over backspace, backspace over push; losers are dropped.
   always_comb begin
      op = OP_NONE;
      if (commit_ev)
         op = OP_COMMIT;
      else if (bksp_ev)
         op = OP_BKSP;
      else if (push_ev)
         op = OP_PUSH;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         edit    <= blank_word(BLANK_CODE);
         Q       <= blank_word(BLANK_CODE);
         count   <= '0;
         full    <= 1'b0;
         q_valid <= 1'b0;
      end else begin
         q_valid <= 1'b0;
         case (op)
            OP_COMMIT: begin
               Q       <= edit;
               q_valid <= 1'b1;
               edit    <= blank_word(BLANK_CODE);
               count   <= '0;
               full    <= 1'b0;
            end
            OP_BKSP: begin
               if (count != 4'd0) begin
                  edit  <= {BLANK_CODE, edit[31:4]};
                  count <= count - 4'd1;
                  full  <= 1'b0;
               end
            end
            OP_PUSH: begin
               if (!full) begin
                  edit  <= {edit[27:0], char_in};
                  count <= count + 4'd1;
                  full  <= (count == 4'd7);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
